// File: rtl/conv_window_iter.sv
// Convolution tap iterator: walks out_y, out_x, ch, ker_y, ker_x and emits padded input coordinates plus strobes.
// Optional CONV_PAD_SKIP_EN: pad taps are stepped one per cycle with en_sum=0, ignoring ready, and pad tied to 0.
module conv_window_iter #(
  parameter int CNT_W    = 8,
  parameter int IMG_W    = 4,
  parameter int IMG_H    = 4,
  parameter int KER_W    = 3,
  parameter int KER_H    = 3,
  parameter int CHANNELS = 2,
  parameter int STRIDE   = 1,
  parameter int PAD      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        out_x,
  output logic [CNT_W-1:0]        out_y,
  output logic [CNT_W-1:0]        ch,
  output logic [CNT_W-1:0]        ker_x,
  output logic [CNT_W-1:0]        ker_y,
  output logic signed [CNT_W-1:0] in_row,
  output logic signed [CNT_W-1:0] in_col,
  output logic                    pad,
  output logic                    en_sum,
  output logic                    acc_clr,
  output logic                    pix_done,
  output logic                    finish,
  output logic [1:0]              dbg_state
);

  localparam int OUT_W = (IMG_W + 2*PAD - KER_W) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2*PAD - KER_H) / STRIDE + 1;
  localparam int MAXV  = 2**(CNT_W-1) - 1;
  localparam int CW    = CNT_W + 2;

  if (IMG_W + 2*PAD < KER_W || IMG_H + 2*PAD < KER_H || OUT_W < 1 || OUT_H < 1 ||
      CHANNELS < 1 || STRIDE < 1 || PAD < 0 ||
      IMG_W > MAXV || IMG_H > MAXV || KER_W > MAXV || KER_H > MAXV ||
      CHANNELS > MAXV || STRIDE > MAXV || PAD > MAXV || OUT_W > MAXV || OUT_H > MAXV) begin : g_bad_cfg
    $error("conv_window_iter: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] KX_MAX = CNT_W'(KER_W - 1);
  localparam logic [CNT_W-1:0] KY_MAX = CNT_W'(KER_H - 1);
  localparam logic [CNT_W-1:0] CH_MAX = CNT_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] OX_MAX = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] OY_MAX = CNT_W'(OUT_H - 1);
  localparam logic signed [CW-1:0] STRIDE_S = CW'(STRIDE);
  localparam logic signed [CW-1:0] PAD_S    = CW'(PAD);
  localparam logic signed [CW-1:0] IMG_W_S  = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S  = CW'(IMG_H);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] ox_q, ox_d, oy_q, oy_d, ch_q, ch_d, kx_q, kx_d, ky_q, ky_d;
  logic [CNT_W-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
  logic tap_pad_q, tap_pad_d, en_sum_q, en_sum_d, acc_clr_q, acc_clr_d;
  logic pix_done_q, pix_done_d, finish_q, finish_d, busy_q, busy_d;
  logic upd, advance, last_tap, pad_c;
  logic signed [CW-1:0] row_c, col_c;

  function automatic logic signed [CW-1:0] coord(input logic [CNT_W-1:0] o,
                                                 input logic [CNT_W-1:0] k);
    coord = $signed({2'b00, o}) * STRIDE_S - PAD_S + $signed({2'b00, k});
  endfunction

  // Handshake: a tap is consumed on a clk edge where en_sum=1 and ready=1;
  // otherwise every output holds. In skip mode a pad tap (en_sum=0) advances unconditionally.
`ifdef CONV_PAD_SKIP_EN
  assign advance = (en_sum_q && ready) || tap_pad_q;
`else
  assign advance = en_sum_q && ready;
`endif

  assign last_tap = (kx_q == KX_MAX) && (ky_q == KY_MAX) && (ch_q == CH_MAX) &&
                    (ox_q == OX_MAX) && (oy_q == OY_MAX);

  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    ch_d       = ch_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    in_row_d   = in_row_q;
    in_col_d   = in_col_q;
    tap_pad_d  = tap_pad_q;
    en_sum_d   = en_sum_q;
    acc_clr_d  = acc_clr_q;
    pix_done_d = pix_done_q;
    busy_d     = busy_q;
    finish_d   = 1'b0;
    upd        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          ox_d    = '0;
          oy_d    = '0;
          ch_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
          upd     = 1'b1;
        end
      end
      S_RUN: begin
        if (advance) begin
          if (last_tap) begin
            state_d    = S_DONE;
            finish_d   = 1'b1;
            en_sum_d   = 1'b0;
            tap_pad_d  = 1'b0;
            acc_clr_d  = 1'b0;
            pix_done_d = 1'b0;
          end else begin
            upd = 1'b1;
            if (kx_q != KX_MAX) kx_d = kx_q + ONE;
            else begin
              kx_d = '0;
              if (ky_q != KY_MAX) ky_d = ky_q + ONE;
              else begin
                ky_d = '0;
                if (ch_q != CH_MAX) ch_d = ch_q + ONE;
                else begin
                  ch_d = '0;
                  if (ox_q != OX_MAX) ox_d = ox_q + ONE;
                  else begin
                    ox_d = '0;
                    oy_d = oy_q + ONE;
                  end
                end
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Coordinates and strobes are precomputed from the next indices so they register with them.
    row_c = coord(oy_d, ky_d);
    col_c = coord(ox_d, kx_d);
    pad_c = (row_c < 0) || (row_c >= IMG_H_S) || (col_c < 0) || (col_c >= IMG_W_S);
    if (upd) begin
      in_row_d   = row_c[CNT_W-1:0];
      in_col_d   = col_c[CNT_W-1:0];
      tap_pad_d  = pad_c;
      acc_clr_d  = (ch_d == '0) && (ky_d == '0) && (kx_d == '0);
      pix_done_d = (kx_d == KX_MAX) && (ky_d == KY_MAX) && (ch_d == CH_MAX);
`ifdef CONV_PAD_SKIP_EN
      en_sum_d   = !pad_c;
`else
      en_sum_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ox_q       <= '0;
      oy_q       <= '0;
      ch_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      in_row_q   <= '0;
      in_col_q   <= '0;
      tap_pad_q  <= 1'b0;
      en_sum_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      pix_done_q <= 1'b0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      ch_q       <= ch_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      in_row_q   <= in_row_d;
      in_col_q   <= in_col_d;
      tap_pad_q  <= tap_pad_d;
      en_sum_q   <= en_sum_d;
      acc_clr_q  <= acc_clr_d;
      pix_done_q <= pix_done_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign ch        = ch_q;
  assign ker_x     = kx_q;
  assign ker_y     = ky_q;
  assign in_row    = in_row_q;
  assign in_col    = in_col_q;
  assign en_sum    = en_sum_q;
  assign acc_clr   = acc_clr_q;
  assign pix_done  = pix_done_q;
  assign finish    = finish_q;
  assign dbg_state = state_q;
`ifdef CONV_PAD_SKIP_EN
  assign pad = 1'b0;
`else
  assign pad = tap_pad_q;
`endif

endmodule

// File: tb/tb_conv_window_iter.sv
// Directed bench for conv_window_iter: tap table on a default pass, stall run, stride-2 instance and mid-pass reset.
module tb_conv_window_iter;

  typedef struct packed {
    logic [7:0] oy, ox, ch, ky, kx, in_row, in_col;
    logic       pad, acc, pix;
  } tap_t;

  typedef struct {
    int   idx;
    tap_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic busy, pad, en_sum, acc_clr, pix_done, finish;
  logic [7:0] out_x, out_y, ch, ker_x, ker_y, in_row, in_col;
  logic [1:0] dbg_state;

  logic start2 = 1'b0;
  logic busy2, pad2, en_sum2, acc_clr2, pix_done2, finish2;
  logic [7:0] out_x2, out_y2, ch2, ker_x2, ker_y2, in_row2, in_col2;
  logic [1:0] dbg_state2;

  tap_t cur;
  tap_t log_a [0:299];
  tap_t log_b [0:299];
  vec_t vecs [0:6];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  conv_window_iter dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .out_x(out_x), .out_y(out_y), .ch(ch), .ker_x(ker_x), .ker_y(ker_y),
    .in_row(in_row), .in_col(in_col), .pad(pad), .en_sum(en_sum),
    .acc_clr(acc_clr), .pix_done(pix_done), .finish(finish), .dbg_state(dbg_state)
  );

  conv_window_iter #(.IMG_W(5), .IMG_H(5), .KER_W(3), .KER_H(3),
                     .CHANNELS(1), .STRIDE(2), .PAD(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .ready(1'b1), .busy(busy2),
    .out_x(out_x2), .out_y(out_y2), .ch(ch2), .ker_x(ker_x2), .ker_y(ker_y2),
    .in_row(in_row2), .in_col(in_col2), .pad(pad2), .en_sum(en_sum2),
    .acc_clr(acc_clr2), .pix_done(pix_done2), .finish(finish2), .dbg_state(dbg_state2)
  );

  assign cur = '{oy: out_y, ox: out_x, ch: ch, ky: ker_y, kx: ker_x,
                 in_row: in_row, in_col: in_col, pad: pad, acc: acc_clr, pix: pix_done};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One pass on dut; taps are logged into log_a. toggle=1 holds ready low on every even cycle.
  task automatic run_pass(input bit toggle, output int taps, output int en_cnt,
                          output int pad1_cnt, output int pad0_cnt, output int fin_cycle,
                          output int freeze_err, output bit after_ok, output bit timeout);
    int k;
    bit stalled;
    tap_t prev;
    taps = 0; en_cnt = 0; pad1_cnt = 0; pad0_cnt = 0; fin_cycle = -1;
    freeze_err = 0; timeout = 1'b1; stalled = 1'b0; prev = '0; k = 0;
    ready = toggle ? 1'b0 : 1'b1;
    pulse_start();
    while (k < 3000) begin
      @(negedge clk);
      if (finish) begin
        fin_cycle = k;
        timeout = 1'b0;
        break;
      end
      if (stalled && cur !== prev) freeze_err++;
      stalled = busy && en_sum && !ready;
      prev = cur;
      if (busy && (!en_sum || ready)) begin
        if (taps < 300) log_a[taps] = cur;
        taps++;
        if (en_sum) en_cnt++;
        if (pad) pad1_cnt++;
        else pad0_cnt++;
      end
      @(posedge clk); #1;
      k++;
      ready = toggle ? k[0] : 1'b1;
    end
    @(negedge clk);
    after_ok = !busy && !finish;
    ready = 1'b1;
  endtask

  initial begin
    int taps, en_cnt, pad1, pad0, fcyc, ferr, diffs, t2, col9, row35, fin_seen;
    bit after_ok, tmo;
    tap_t e;
    int exp_en, exp_pad1;

    vecs[0] = '{0,   '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hff, 8'hff, 1'b1, 1'b1, 1'b0}};
    vecs[1] = '{4,   '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{17,  '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{18,  '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'hff, 8'h00, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{100, '{8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{144, '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'h01, 8'hff, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{287, '{8'd3, 8'd3, 8'd1, 8'd2, 8'd2, 8'h04, 8'h04, 1'b1, 1'b0, 1'b1}};
`ifdef CONV_PAD_SKIP_EN
    exp_en = 200; exp_pad1 = 0;
`else
    exp_en = 288; exp_pad1 = 88;
`endif

    // Clock/reset block
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_state", {cur, busy, en_sum, finish, dbg_state}, 64'd0);

    // Default pass with ready held high
    run_pass(1'b0, taps, en_cnt, pad1, pad0, fcyc, ferr, after_ok, tmo);
    check("p1_timeout", {63'd0, tmo}, 64'd0);
    check("p1_taps", taps, 288);
    check("p1_en_sum", en_cnt, exp_en);
    check("p1_pad1", pad1, exp_pad1);
    check("p1_pad0", pad0, 288 - exp_pad1);
    check("p1_finish_cycle", fcyc, 288);
    check("p1_idle_after", {63'd0, after_ok}, 64'd1);
    for (int i = 0; i < 7; i++) begin
      e = vecs[i].exp;
`ifdef CONV_PAD_SKIP_EN
      e.pad = 1'b0;
`endif
      check($sformatf("tap_%0d", vecs[i].idx), log_a[vecs[i].idx], e);
    end
    for (int i = 0; i < 300; i++) log_b[i] = log_a[i];

    // Stall run: ready alternates, starting low on the first tap
    run_pass(1'b1, taps, en_cnt, pad1, pad0, fcyc, ferr, after_ok, tmo);
    check("p2_timeout", {63'd0, tmo}, 64'd0);
    check("p2_taps", taps, 288);
    check("p2_freeze", ferr, 0);
`ifndef CONV_PAD_SKIP_EN
    check("p2_finish_cycle", fcyc, 576);
`endif
    diffs = 0;
    for (int i = 0; i < 288; i++) if (log_a[i] !== log_b[i]) diffs++;
    check("p2_same_sequence", diffs, 0);

    // Stride-2 instance, 5x5 image, no padding
    t2 = 0; col9 = -1; row35 = -1; fin_seen = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (finish2) begin
        fin_seen = 1;
        break;
      end
      if (busy2 && en_sum2) begin
        if (t2 == 9)  col9 = int'(in_col2) | (int'(ker_x2) << 8) | (int'(out_x2) << 16);
        if (t2 == 35) row35 = int'(in_row2);
        t2++;
      end
    end
    check("s2_finished", fin_seen, 1);
    check("s2_taps", t2, 36);
    check("s2_tap9_col", col9, 32'h0001_0002);
    check("s2_tap35_row", row35, 4);

    // Mid-pass reset at tap 100, then a fresh pass
    pulse_start();
    repeat (99) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_cleared", {cur, busy, en_sum}, 64'd0);
    fin_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (finish || busy) fin_seen++;
    end
    check("abort_no_finish", fin_seen, 0);
    run_pass(1'b0, taps, en_cnt, pad1, pad0, fcyc, ferr, after_ok, tmo);
    check("p3_taps", taps, 288);
    e = vecs[0].exp;
`ifdef CONV_PAD_SKIP_EN
    e.pad = 1'b0;
`endif
    check("p3_tap0", log_a[0], e);
    check("p3_finish_cycle", fcyc, 288);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
